// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit
//
// Sequenced IF/ID/EX/MEM/WB controller for the TSC 16-bit CPU. It decodes the
// instruction register fields held by the datapath and drives the datapath
// strobes and multiplexer selects one phase at a time. Fetch and memory phases
// wait on the mem_ready handshake. The unit also counts retired instructions.
//
// Ports
//   clk, reset_n      rising-edge clock, asynchronous active-low reset
//   opcode, func_code IR[15:12] and IR[5:0]
//   mem_ready         completes the pending MemRead/MemWrite this cycle
//   PCWrite .. ALUSrcA  single-bit datapath strobes/selects
//   ALUSrcB           00 B, 01 +1, 10 sign-ext imm, 11 zero-ext imm
//   RegDst            00 rt, 01 rd, 10 r2 (link)
//   MemtoReg          00 ALUOut, 01 MDR, 10 PC
//   PCSource          00 ALU, 01 ALUOut, 10 jump target, 11 reg A
//   ALUOperation      ALU function code
//   branch_type       branch condition, valid with PCWriteCond
//   isWWD, halted, illegal, inst_done  status
//   num_inst          retired-instruction count, wraps
module multicycle_control_unit #(
    parameter int ALU_OP_W = 4,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [3:0]          opcode,
    input  logic [5:0]          func_code,
    input  logic                mem_ready,
    output logic                PCWrite,
    output logic                PCWriteCond,
    output logic                IorD,
    output logic                MemRead,
    output logic                MemWrite,
    output logic                IRWrite,
    output logic                RegWrite,
    output logic                ALUSrcA,
    output logic [1:0]          ALUSrcB,
    output logic [1:0]          RegDst,
    output logic [1:0]          MemtoReg,
    output logic [1:0]          PCSource,
    output logic [ALU_OP_W-1:0] ALUOperation,
    output logic [1:0]          branch_type,
    output logic                isWWD,
    output logic                halted,
    output logic                illegal,
    output logic                inst_done,
    output logic [CNT_W-1:0]    num_inst
);

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_HALT = 3'd5
    } state_t;

    localparam logic [ALU_OP_W-1:0] ALU_ADD = ALU_OP_W'(0);
    localparam logic [ALU_OP_W-1:0] ALU_SUB = ALU_OP_W'(1);
    localparam logic [ALU_OP_W-1:0] ALU_ORR = ALU_OP_W'(3);
    localparam logic [ALU_OP_W-1:0] ALU_LHI = ALU_OP_W'(8);

    localparam logic [3:0] OP_ADI = 4'd4;
    localparam logic [3:0] OP_ORI = 4'd5;
    localparam logic [3:0] OP_LHI = 4'd6;
    localparam logic [3:0] OP_LWD = 4'd7;
    localparam logic [3:0] OP_SWD = 4'd8;
    localparam logic [3:0] OP_JMP = 4'd9;
    localparam logic [3:0] OP_JAL = 4'd10;
    localparam logic [3:0] OP_R   = 4'd15;

    localparam logic [5:0] FN_JPR = 6'd25;
    localparam logic [5:0] FN_JRL = 6'd26;
    localparam logic [5:0] FN_WWD = 6'd28;
    localparam logic [5:0] FN_HLT = 6'd29;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   num_q;

    // Instruction decode of the IR fields
    logic is_rtype, is_branch, is_r_alu;
    logic is_jpr, is_jrl, is_wwd, is_hlt, legal;

    always_comb begin
        is_rtype  = (opcode == OP_R);
        is_branch = (opcode[3:2] == 2'b00);
        is_r_alu  = is_rtype && (func_code[5:3] == 3'b000);
        is_jpr    = is_rtype && (func_code == FN_JPR);
        is_jrl    = is_rtype && (func_code == FN_JRL);
        is_wwd    = is_rtype && (func_code == FN_WWD);
        is_hlt    = is_rtype && (func_code == FN_HLT);
        legal     = (opcode <= OP_JAL) ||
                    (is_r_alu || is_jpr || is_jrl || is_wwd || is_hlt);
    end

    // Next-state and output decode; everything is a function of (state, IR)
    logic                pc_write_c, pc_write_cond_c, iord_c, mem_read_c;
    logic                mem_write_c, ir_write_c, reg_write_c, alu_src_a_c;
    logic [1:0]          alu_src_b_c, reg_dst_c, mem_to_reg_c, pc_source_c;
    logic [1:0]          branch_type_c;
    logic [ALU_OP_W-1:0] alu_op_c;
    logic                is_wwd_c, halted_c, illegal_c, inst_done_c;

    always_comb begin
        state_d         = state_q;
        pc_write_c      = 1'b0;
        pc_write_cond_c = 1'b0;
        iord_c          = 1'b0;
        mem_read_c      = 1'b0;
        mem_write_c     = 1'b0;
        ir_write_c      = 1'b0;
        reg_write_c     = 1'b0;
        alu_src_a_c     = 1'b0;
        alu_src_b_c     = 2'b00;
        reg_dst_c       = 2'b00;
        mem_to_reg_c    = 2'b00;
        pc_source_c     = 2'b00;
        branch_type_c   = 2'b00;
        alu_op_c        = ALU_ADD;
        is_wwd_c        = 1'b0;
        halted_c        = 1'b0;
        illegal_c       = 1'b0;

        case (state_q)
            S_IF: begin
                // PC+1 is computed every fetch cycle but only committed
                // together with the instruction word.
                mem_read_c  = 1'b1;
                alu_src_b_c = 2'b01;
                if (mem_ready) begin
                    ir_write_c = 1'b1;
                    pc_write_c = 1'b1;
                    state_d    = S_ID;
                end
            end

            S_ID: begin
                // PC + sign-ext offset into ALUOut for a possible branch
                alu_src_b_c = 2'b10;
                state_d     = S_IF;
                if (!legal) begin
                    illegal_c = 1'b1;
                end else if (opcode == OP_JMP) begin
                    pc_write_c  = 1'b1;
                    pc_source_c = 2'b10;
                end else if (opcode == OP_JAL || is_jrl) begin
                    reg_write_c  = 1'b1;
                    reg_dst_c    = 2'b10;
                    mem_to_reg_c = 2'b10;
                    pc_write_c   = 1'b1;
                    pc_source_c  = is_jrl ? 2'b11 : 2'b10;
                end else if (is_jpr) begin
                    pc_write_c  = 1'b1;
                    pc_source_c = 2'b11;
                end else if (is_wwd) begin
                    is_wwd_c = 1'b1;
                end else if (is_hlt) begin
                    state_d = S_HALT;
                end else begin
                    state_d = S_EX;
                end
            end

            S_EX: begin
                alu_src_a_c = 1'b1;
                state_d     = S_IF;
                if (is_branch) begin
                    alu_src_b_c     = 2'b00;
                    alu_op_c        = ALU_SUB;
                    pc_write_cond_c = 1'b1;
                    pc_source_c     = 2'b01;
                    branch_type_c   = opcode[1:0];
                end else if (is_rtype) begin
                    alu_src_b_c = 2'b00;
                    alu_op_c    = ALU_OP_W'(func_code[2:0]);
                    state_d     = S_WB;
                end else if (opcode == OP_ADI) begin
                    alu_src_b_c = 2'b10;
                    state_d     = S_WB;
                end else if (opcode == OP_LHI) begin
                    alu_src_b_c = 2'b10;
                    alu_op_c    = ALU_LHI;
                    state_d     = S_WB;
                end else if (opcode == OP_ORI) begin
                    alu_src_b_c = 2'b11;
                    alu_op_c    = ALU_ORR;
                    state_d     = S_WB;
                end else if (opcode == OP_LWD || opcode == OP_SWD) begin
                    alu_src_b_c = 2'b10;
                    state_d     = S_MEM;
                end
            end

            S_MEM: begin
                // Strobes stay up for the whole wait so the memory sees a
                // stable request until it answers.
                iord_c = 1'b1;
                if (opcode == OP_LWD) begin
                    mem_read_c = 1'b1;
                    if (mem_ready) state_d = S_WB;
                end else if (opcode == OP_SWD) begin
                    mem_write_c = 1'b1;
                    if (mem_ready) state_d = S_IF;
                end else begin
                    state_d = S_IF;
                end
            end

            S_WB: begin
                reg_write_c  = 1'b1;
                reg_dst_c    = is_rtype ? 2'b01 : 2'b00;
                mem_to_reg_c = (opcode == OP_LWD) ? 2'b01 : 2'b00;
                state_d      = S_IF;
            end

            S_HALT: begin
                halted_c = 1'b1;
            end

            default: begin
                state_d = S_IF;
            end
        endcase

        // An instruction retires on the edge that returns to fetch; HLT
        // retires on its decode cycle since it never returns.
        inst_done_c = ((state_d == S_IF) && (state_q != S_IF)) ||
                      ((state_q == S_ID) && legal && is_hlt);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IF;
            num_q   <= '0;
        end else begin
            state_q <= state_d;
            if (inst_done_c) num_q <= num_q + CNT_W'(1);
        end
    end

    // All outputs read zero while reset is held, including the fetch read
    assign PCWrite      = reset_n & pc_write_c;
    assign PCWriteCond  = reset_n & pc_write_cond_c;
    assign IorD         = reset_n & iord_c;
    assign MemRead      = reset_n & mem_read_c;
    assign MemWrite     = reset_n & mem_write_c;
    assign IRWrite      = reset_n & ir_write_c;
    assign RegWrite     = reset_n & reg_write_c;
    assign ALUSrcA      = reset_n & alu_src_a_c;
    assign ALUSrcB      = reset_n ? alu_src_b_c   : 2'b00;
    assign RegDst       = reset_n ? reg_dst_c     : 2'b00;
    assign MemtoReg     = reset_n ? mem_to_reg_c  : 2'b00;
    assign PCSource     = reset_n ? pc_source_c   : 2'b00;
    assign ALUOperation = reset_n ? alu_op_c      : '0;
    assign branch_type  = reset_n ? branch_type_c : 2'b00;
    assign isWWD        = reset_n & is_wwd_c;
    assign halted       = reset_n & halted_c;
    assign illegal      = reset_n & illegal_c;
    assign inst_done    = reset_n & inst_done_c;
    assign num_inst     = num_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
module tb_multicycle_control_unit;

  localparam int ALU_OP_W = 4;
  localparam int CNT_W    = 4;

  logic                clk = 1'b0;
  logic                reset_n;
  logic [3:0]          opcode;
  logic [5:0]          func_code;
  logic                mem_ready;
  logic                PCWrite, PCWriteCond, IorD, MemRead, MemWrite;
  logic                IRWrite, RegWrite, ALUSrcA;
  logic [1:0]          ALUSrcB, RegDst, MemtoReg, PCSource, branch_type;
  logic [ALU_OP_W-1:0] ALUOperation;
  logic                isWWD, halted, illegal, inst_done;
  logic [CNT_W-1:0]    num_inst;

  multicycle_control_unit #(.ALU_OP_W(ALU_OP_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .func_code(func_code),
    .mem_ready(mem_ready), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
    .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .PCSource(PCSource),
    .ALUOperation(ALUOperation), .branch_type(branch_type), .isWWD(isWWD),
    .halted(halted), .illegal(illegal), .inst_done(inst_done),
    .num_inst(num_inst)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pcw, pcwc, iord, mrd, mwr, irw, rgw, srca;
    logic [1:0] srcb, rdst, m2r, pcsrc;
    logic [3:0] aluop;
    logic [1:0] btype;
    logic       wwd, hlt, ill, done;
  } ctl_t;

  typedef enum {K_ALU, K_ADI, K_ORI, K_LHI, K_LWD, K_SWD, K_BR, K_JMP,
                K_JAL, K_JPR, K_JRL, K_WWD, K_HLT, K_ILL} kind_t;
  typedef enum {P_F, P_D, P_E, P_M, P_W, P_H} phase_t;

  ctl_t obs;
  assign obs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                RegWrite, ALUSrcA, ALUSrcB, RegDst, MemtoReg, PCSource,
                ALUOperation, branch_type, isWWD, halted, illegal, inst_done};

  int               n_cmp = 0;
  int               n_bad = 0;
  logic [CNT_W-1:0] exp_cnt;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic kind_t classify(input int op, input int fn);
    case (op)
      0, 1, 2, 3: return K_BR;
      4:  return K_ADI;
      5:  return K_ORI;
      6:  return K_LHI;
      7:  return K_LWD;
      8:  return K_SWD;
      9:  return K_JMP;
      10: return K_JAL;
      15: begin
        if (fn < 8)   return K_ALU;
        if (fn == 25) return K_JPR;
        if (fn == 26) return K_JRL;
        if (fn == 28) return K_WWD;
        if (fn == 29) return K_HLT;
        return K_ILL;
      end
      default: return K_ILL;
    endcase
  endfunction

  // Expected control word for one cycle of an instruction in a given phase
  function automatic ctl_t expect_ctl(input phase_t ph, input kind_t k,
                                      input int op, input int fn,
                                      input bit rdy, input bit last);
    ctl_t e;
    e = '0;
    case (ph)
      P_F: begin
        e.mrd = 1; e.srcb = 2'b01;
        if (rdy) begin e.irw = 1; e.pcw = 1; end
      end
      P_D: begin
        e.srcb = 2'b10;
        case (k)
          K_JMP: begin e.pcw = 1; e.pcsrc = 2'b10; end
          K_JAL: begin e.rgw = 1; e.rdst = 2'b10; e.m2r = 2'b10; e.pcw = 1; e.pcsrc = 2'b10; end
          K_JPR: begin e.pcw = 1; e.pcsrc = 2'b11; end
          K_JRL: begin e.rgw = 1; e.rdst = 2'b10; e.m2r = 2'b10; e.pcw = 1; e.pcsrc = 2'b11; end
          K_WWD: e.wwd = 1;
          K_ILL: e.ill = 1;
          default: ;
        endcase
      end
      P_E: begin
        e.srca = 1;
        case (k)
          K_ALU: begin e.srcb = 2'b00; e.aluop = 4'(fn); end
          K_ADI: e.srcb = 2'b10;
          K_LHI: begin e.srcb = 2'b10; e.aluop = 4'd8; end
          K_ORI: begin e.srcb = 2'b11; e.aluop = 4'd3; end
          K_LWD, K_SWD: e.srcb = 2'b10;
          K_BR: begin
            e.aluop = 4'd1; e.pcwc = 1; e.pcsrc = 2'b01; e.btype = 2'(op);
          end
          default: ;
        endcase
      end
      P_M: begin
        e.iord = 1;
        if (k == K_LWD) e.mrd = 1;
        if (k == K_SWD) e.mwr = 1;
      end
      P_W: begin
        e.rgw  = 1;
        e.rdst = (k == K_ALU) ? 2'b01 : 2'b00;
        e.m2r  = (k == K_LWD) ? 2'b01 : 2'b00;
      end
      P_H: e.hlt = 1;
      default: ;
    endcase
    if (last && ((ph != P_F && ph != P_M) || rdy)) e.done = 1;
    return e;
  endfunction

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    chk("rst_out_async", 32'(obs), 32'd0);
    chk("rst_cnt_async", 32'(num_inst), 32'd0);
    @(negedge clk);
    chk("rst_out", 32'(obs), 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    exp_cnt = '0;
  endtask

  // mode 0: mem_ready always 1; mode 1: random; mode 2: 3 stall cycles in MEM
  // abort_at >= 0 pulses reset after that many cycles of the instruction
  task automatic run_inst(input int op, input int fn, input int mode,
                          input int abort_at, output int cycles);
    kind_t    k;
    phase_t   seq[$];
    int       idx, stall;
    bit       rdy, last, memph;
    ctl_t     e;
    k = classify(op, fn);
    seq = '{P_F, P_D};
    case (k)
      K_ALU, K_ADI, K_ORI, K_LHI: begin seq.push_back(P_E); seq.push_back(P_W); end
      K_LWD: begin seq.push_back(P_E); seq.push_back(P_M); seq.push_back(P_W); end
      K_SWD: begin seq.push_back(P_E); seq.push_back(P_M); end
      K_BR:  seq.push_back(P_E);
      K_HLT: for (int i = 0; i < 6; i++) seq.push_back(P_H);
      default: ;
    endcase
    opcode    = 4'(op);
    func_code = 6'(fn);
    idx = 0; stall = 0; cycles = 0;
    while (idx < seq.size()) begin
      if (cycles == abort_at) begin
        do_reset();
        cycles = -1;
        return;
      end
      case (mode)
        0: rdy = 1'b1;
        1: rdy = (stall >= 6) ? 1'b1 : ($urandom_range(0, 3) != 0);
        default: rdy = (seq[idx] != P_M) || (stall >= 3);
      endcase
      mem_ready = rdy;
      last = (k == K_HLT) ? (seq[idx] == P_D) : (idx == seq.size() - 1);
      e = expect_ctl(seq[idx], k, op, fn, rdy, last);
      @(negedge clk);
      chk("ctl", 32'(obs), 32'(e));
      chk("num_inst", 32'(num_inst), 32'(exp_cnt));
      @(posedge clk); #1;
      cycles++;
      memph = (seq[idx] == P_F) || (seq[idx] == P_M);
      if (memph && !rdy) begin
        stall++;
      end else begin
        stall = 0;
        if (e.done) exp_cnt++;
        idx++;
      end
    end
  endtask

  initial begin
    int c, op, fn, ab, r;
    reset_n = 1'b0; opcode = '0; func_code = '0; mem_ready = 1'b0;
    exp_cnt = '0;
    @(posedge clk); #1;
    do_reset();

    run_inst(15, 0, 0, -1, c);  chk("add_cycles", c, 4);
    run_inst(7, 0, 2, -1, c);   chk("lwd_stall_cycles", c, 8);
    run_inst(1, 0, 0, -1, c);   chk("beq_cycles", c, 3);
    run_inst(10, 0, 0, -1, c);  chk("jal_cycles", c, 2);
    run_inst(15, 28, 0, -1, c); chk("wwd_cycles", c, 2);
    run_inst(8, 0, 0, -1, c);   chk("swd_cycles", c, 4);
    run_inst(6, 0, 0, -1, c);   chk("lhi_cycles", c, 4);
    run_inst(12, 0, 0, -1, c);  chk("illegal_cycles", c, 2);
    for (int i = 0; i < 18; i++) run_inst(9, 0, 0, -1, c);
    chk("jmp_wrap_cnt", 32'(num_inst), 32'(exp_cnt));

    for (int i = 0; i < 300; i++) begin
      op = $urandom_range(0, 15);
      fn = $urandom_range(0, 63);
      if (op == 15) begin
        r = $urandom_range(0, 11);
        if (r < 8)        fn = r;
        else if (r == 8)  fn = 25;
        else if (r == 9)  fn = 26;
        else if (r == 10) fn = 28;
        else              fn = (fn == 29) ? 30 : fn;
      end
      ab = ($urandom_range(0, 24) == 0) ? $urandom_range(0, 4) : -1;
      run_inst(op, fn, 1, ab, c);
    end

    run_inst(15, 29, 1, -1, c);
    chk("halt_cnt_frozen", 32'(num_inst), 32'(exp_cnt));
    do_reset();
    run_inst(9, 0, 0, -1, c);   chk("post_halt_jmp", c, 2);
    chk("post_halt_cnt", 32'(num_inst), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
